cp0_exception_unit: RTL

//  Coprocessor-0 for the unpipelined core. Consumes execute-stage status (unknown_func, arithmetic_overflow,

---
 rtl/cp0_pkg.sv | 33 +++
 rtl/cp0_timer.sv | 40 ++++
 rtl/cp0_exception_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause bit positions
// and the handler-mode enum used by the exception unit.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_IM_LSB  = 8;
    localparam int CA_EXC_LSB = 2;
    localparam int CA_IP_LSB  = 8;

    typedef enum logic {
        MODE_USER = 1'b0,
        MODE_EXC  = 1'b1
    } mode_e;

    // Reserved instruction outranks overflow; with neither it must be an interrupt.
    function automatic logic [4:0] exc_code(input logic ri, input logic ov);
        if (ri)      return EXC_RI;
        else if (ov) return EXC_OV;
        else         return EXC_INT;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0: Count free-runs every cycle, a Count==Compare match
// raises a sticky IP7 that only a Compare write clears.
module cp0_timer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_count,
    input  logic        i_wr_compare,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ip7
);

    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        ip7_q,     ip7_d;

    always_comb begin
        count_d   = i_wr_count ? i_wdata : count_q + 32'd1;
        compare_d = i_wr_compare ? i_wdata : compare_q;
        ip7_d     = i_wr_compare ? 1'b0 : (ip7_q | (count_q == compare_q));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            ip7_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ip7_q     <= ip7_d;
        end
    end

    assign o_count   = count_q;
    assign o_compare = compare_q;
    assign o_ip7     = ip7_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception unit: Status/Cause/EPC, exception/interrupt arbitration, ERET and mfc0/mtc0.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN (it then drives Cause.IP7).
module cp0_exception_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
    parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic        i_unknown_func,
    input  logic        i_arithmetic_overflow,
    input  logic        i_eret,
    input  logic        i_mfc0,
    input  logic        i_mtc0,
    input  logic [4:0]  i_cp0_addr,
    input  logic [31:0] i_wdata,
    input  logic [5:0]  i_irq,
    output logic        o_exception,
    output logic [31:0] o_vector,
    output logic [31:0] o_rdata,
    output logic        o_exl
);

    mode_e       mode_q,    mode_d;
    logic        ie_q,      ie_d;
    logic [7:0]  im_q,      im_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [1:0]  ip_sw_q,   ip_sw_d;
    logic [4:0]  ip_hw_q,   ip_hw_d;
    logic [31:0] epc_q,     epc_d;

    logic        ip7;
    logic [7:0]  cause_ip;
    logic        fault_ri, fault_ov, sync_fault, int_take, take_exc;
    logic        do_eret, do_mtc0;
    logic [31:0] status_rd, cause_rd;

    // i_valid acts as the retire strobe: an instruction's flags are only honoured in the
    // cycle i_valid is high; there is no back-pressure, the unit accepts every retiring
    // instruction. With i_valid low only interrupt sampling (and the timer) move.
    always_comb begin
        fault_ri   = i_valid & i_unknown_func;
        fault_ov   = i_valid & i_arithmetic_overflow;
        sync_fault = fault_ri | fault_ov;
        int_take   = i_valid & ie_q & (mode_q == MODE_USER) & (|(cause_ip & im_q)) & ~sync_fault;
        take_exc   = sync_fault | int_take;
        do_eret    = i_valid & i_eret & ~take_exc;
        do_mtc0    = i_valid & i_mtc0 & ~take_exc;
    end

    always_comb begin
        mode_d    = mode_q;
        ie_d      = ie_q;
        im_d      = im_q;
        exccode_d = exccode_q;
        ip_sw_d   = ip_sw_q;
        ip_hw_d   = i_irq[4:0];
        epc_d     = epc_q;
        if (take_exc) begin
            mode_d    = MODE_EXC;
            exccode_d = exc_code(fault_ri, fault_ov);
            // A fault inside the handler must not lose the original return address.
            if (mode_q == MODE_USER) begin
                epc_d = i_pc;
            end
        end else begin
            if (do_eret) begin
                mode_d = MODE_USER;
            end
            if (do_mtc0) begin
                case (i_cp0_addr)
                    CP0_REG_STATUS: begin
                        ie_d   = i_wdata[ST_IE];
                        mode_d = i_wdata[ST_EXL] ? MODE_EXC : MODE_USER;
                        im_d   = i_wdata[ST_IM_LSB +: 8];
                    end
                    CP0_REG_CAUSE:  ip_sw_d = i_wdata[CA_IP_LSB +: 2];
                    CP0_REG_EPC:    epc_d   = i_wdata;
                    default:        ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q    <= STATUS_RESET[ST_EXL] ? MODE_EXC : MODE_USER;
            ie_q      <= STATUS_RESET[ST_IE];
            im_q      <= STATUS_RESET[ST_IM_LSB +: 8];
            exccode_q <= 5'd0;
            ip_sw_q   <= 2'd0;
            ip_hw_q   <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            mode_q    <= mode_d;
            ie_q      <= ie_d;
            im_q      <= im_d;
            exccode_q <= exccode_d;
            ip_sw_q   <= ip_sw_d;
            ip_hw_q   <= ip_hw_d;
            epc_q     <= epc_d;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] timer_count, timer_compare;
    logic        timer_ip7, wr_count, wr_compare;
    logic        unused_irq5;

    assign wr_count    = do_mtc0 & (i_cp0_addr == CP0_REG_COUNT);
    assign wr_compare  = do_mtc0 & (i_cp0_addr == CP0_REG_COMPARE);
    assign unused_irq5 = i_irq[5];

    cp0_timer u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr_count   (wr_count),
        .i_wr_compare (wr_compare),
        .i_wdata      (i_wdata),
        .o_count      (timer_count),
        .o_compare    (timer_compare),
        .o_ip7        (timer_ip7)
    );

    assign ip7 = timer_ip7;
`else
    logic irq5_q, irq5_d;

    always_comb begin
        irq5_d = i_irq[5];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            irq5_q <= 1'b0;
        end else begin
            irq5_q <= irq5_d;
        end
    end

    assign ip7 = irq5_q;
`endif

    assign cause_ip  = {ip7, ip_hw_q, ip_sw_q};
    assign status_rd = {16'd0, im_q, 6'd0, (mode_q == MODE_EXC), ie_q};
    assign cause_rd  = {16'd0, cause_ip, 1'b0, exccode_q, 2'd0};

    always_comb begin
        o_rdata = 32'd0;
        case (i_cp0_addr)
            CP0_REG_STATUS:  o_rdata = status_rd;
            CP0_REG_CAUSE:   o_rdata = cause_rd;
            CP0_REG_EPC:     o_rdata = epc_q;
`ifdef CP0_TIMER_EN
            CP0_REG_COUNT:   o_rdata = timer_count;
            CP0_REG_COMPARE: o_rdata = timer_compare;
`endif
            default:         o_rdata = 32'd0;
        endcase
    end

    assign o_exception = take_exc & ~i_rst;
    assign o_vector    = i_rst ? 32'd0 : (take_exc ? HANDLER_ADDR : epc_q);
    assign o_exl       = ~i_rst & (mode_q == MODE_EXC);

endmodule
